// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the shared-RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of an index selecting one of n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Rotating-priority encoder: first requesting port at or after ptr, wrapping to port 0.
module mem_arb_rr_pick #(
  parameter int NUM_RD = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_RD-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [IDX_W-1:0]  grant_o,
  output logic              valid_o
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Descending scan leaves the lowest hit in each half; the half at/after ptr wins.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_RD - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        if (i >= int'(ptr_i)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end
      end
    end
    grant_o = hi_found ? hi_idx : lo_idx;
    valid_o = hi_found | lo_found;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises NUM_RD read ports and one write port onto a single-port RAM
// with RAM_LAT read latency; writes always win, reads use fixed or round-robin priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int ADDR_W   = 14,
  parameter int NUM_RD   = 4,
  parameter int RAM_LAT  = 1,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_req,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  input  logic [NUM_RD-1:0]          rd_req,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_ready,
  output logic                       stall,
  output logic                       busy,
  output logic                       ram_read,
  output logic                       ram_write,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_wdata,
  input  logic [DATA_W-1:0]          ram_rdata
);

  localparam int IDX_W = idx_width(NUM_RD);
  localparam int LAT_W = idx_width(RAM_LAT);

  arb_state_t                state_q;
  logic [IDX_W-1:0]          grant_q;
  logic                      is_wr_q;
  logic [IDX_W-1:0]          ptr_q;
  logic [IDX_W-1:0]          ptr_d;
  logic [LAT_W-1:0]          lat_q;
  logic [NUM_RD*DATA_W-1:0]  rd_data_q;
  logic                      ram_read_q;
  logic                      ram_write_q;
  logic [ADDR_W-1:0]         ram_addr_q;
  logic [DATA_W-1:0]         ram_wdata_q;
  logic [NUM_RD-1:0]         rd_ready_q;
  logic                      wr_ready_q;

  logic [IDX_W-1:0]          pick_ptr;
  logic [IDX_W-1:0]          pick_grant;
  logic                      pick_valid;
  logic [ADDR_W-1:0]         sel_addr;

  // Fixed mode is the rotating picker with its pointer pinned at port 0.
  assign pick_ptr = (ARB_MODE == ARB_RR) ? ptr_q : '0;

  mem_arb_rr_pick #(
    .NUM_RD (NUM_RD),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i   (rd_req),
    .ptr_i   (pick_ptr),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  assign ptr_d = (pick_grant == IDX_W'(NUM_RD - 1)) ? '0 : pick_grant + IDX_W'(1);

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (pick_grant == IDX_W'(i)) sel_addr = rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      is_wr_q     <= 1'b0;
      ptr_q       <= '0;
      lat_q       <= '0;
      rd_data_q   <= '0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_ready_q  <= '0;
      wr_ready_q  <= 1'b0;
    end else begin
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      rd_ready_q  <= '0;
      wr_ready_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_req) begin
            state_q     <= ISSUE;
            is_wr_q     <= 1'b1;
            ram_write_q <= 1'b1;
            ram_addr_q  <= wr_addr;
            ram_wdata_q <= wr_data;
          end else if (pick_valid) begin
            state_q    <= ISSUE;
            is_wr_q    <= 1'b0;
            grant_q    <= pick_grant;
            ram_read_q <= 1'b1;
            ram_addr_q <= sel_addr;
            if (ARB_MODE == ARB_RR) ptr_q <= ptr_d;
          end
        end
        ISSUE: begin
          lat_q <= '0;
          if (is_wr_q) begin
            state_q    <= DONE;
            wr_ready_q <= 1'b1;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // Last latency cycle: RAM data is valid now, capture and pulse ready next.
          if (lat_q == LAT_W'(RAM_LAT - 1)) begin
            state_q <= DONE;
            for (int i = 0; i < NUM_RD; i++) begin
              if (grant_q == IDX_W'(i)) rd_data_q[i*DATA_W +: DATA_W] <= ram_rdata;
              rd_ready_q[i] <= (grant_q == IDX_W'(i));
            end
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_ready  = wr_ready_q;
  assign rd_ready  = rd_ready_q;
  assign rd_data   = rd_data_q;
  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != IDLE);
  assign stall     = (|(rd_req & ~rd_ready_q)) | (wr_req & ~wr_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: dut0 = 4 ports, RAM_LAT 1, fixed priority;
// dut1 = 8 ports, RAM_LAT 3, round-robin. Each has its own RAM model.
module tb_mem_port_arbiter;
  localparam int DW = 10;
  localparam int AW = 14;
  localparam int NRD [2] = '{4, 8};
  localparam int LAT [2] = '{1, 3};
  localparam int RR  [2] = '{0, 1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    rq [2];
  logic [AW-1:0] ra [2][8];
  logic          wq [2];
  logic [AW-1:0] wa [2];
  logic [DW-1:0] wd [2];

  logic [4*AW-1:0] d0_rd_addr;
  logic [8*AW-1:0] d1_rd_addr;
  logic [4*DW-1:0] d0_rd_data;
  logic [8*DW-1:0] d1_rd_data;
  logic [3:0]      d0_rd_ready;
  logic [7:0]      d1_rd_ready;
  logic            d0_wr_ready, d1_wr_ready, d0_stall, d1_stall, d0_busy, d1_busy;
  logic            d0_ram_read, d1_ram_read, d0_ram_write, d1_ram_write;
  logic [AW-1:0]   d0_ram_addr, d1_ram_addr;
  logic [DW-1:0]   d0_ram_wdata, d1_ram_wdata, d0_ram_rdata, d1_ram_rdata;

  always_comb begin
    for (int i = 0; i < 4; i++) d0_rd_addr[i*AW +: AW] = ra[0][i];
    for (int i = 0; i < 8; i++) d1_rd_addr[i*AW +: AW] = ra[1][i];
  end

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .RAM_LAT(1), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .wr_req(wq[0]), .wr_addr(wa[0]), .wr_data(wd[0]), .wr_ready(d0_wr_ready),
    .rd_req(rq[0][3:0]), .rd_addr(d0_rd_addr), .rd_data(d0_rd_data), .rd_ready(d0_rd_ready),
    .stall(d0_stall), .busy(d0_busy), .ram_read(d0_ram_read), .ram_write(d0_ram_write),
    .ram_addr(d0_ram_addr), .ram_wdata(d0_ram_wdata), .ram_rdata(d0_ram_rdata));

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(8), .RAM_LAT(3), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .wr_req(wq[1]), .wr_addr(wa[1]), .wr_data(wd[1]), .wr_ready(d1_wr_ready),
    .rd_req(rq[1]), .rd_addr(d1_rd_addr), .rd_data(d1_rd_data), .rd_ready(d1_rd_ready),
    .stall(d1_stall), .busy(d1_busy), .ram_read(d1_ram_read), .ram_write(d1_ram_write),
    .ram_addr(d1_ram_addr), .ram_wdata(d1_ram_wdata), .ram_rdata(d1_ram_rdata));

  // Uniform per-DUT views of the outputs.
  logic [DW-1:0] o_rd [2][8];
  logic [7:0]    o_rdy [2];
  logic          o_wrdy [2], o_rs [2], o_ws [2], o_busy [2], o_stall [2];
  logic [AW-1:0] o_addr [2];
  logic [DW-1:0] o_wdata [2];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      o_rd[0][i] = '0;
      o_rd[1][i] = d1_rd_data[i*DW +: DW];
    end
    for (int i = 0; i < 4; i++) o_rd[0][i] = d0_rd_data[i*DW +: DW];
    o_rdy[0] = {4'b0, d0_rd_ready};  o_rdy[1] = d1_rd_ready;
    o_wrdy[0] = d0_wr_ready;         o_wrdy[1] = d1_wr_ready;
    o_rs[0] = d0_ram_read;           o_rs[1] = d1_ram_read;
    o_ws[0] = d0_ram_write;          o_ws[1] = d1_ram_write;
    o_busy[0] = d0_busy;             o_busy[1] = d1_busy;
    o_stall[0] = d0_stall;           o_stall[1] = d1_stall;
    o_addr[0] = d0_ram_addr;         o_addr[1] = d1_ram_addr;
    o_wdata[0] = d0_ram_wdata;       o_wdata[1] = d1_ram_wdata;
  end

  // RAM models: unwritten locations read as init_val(addr).
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return DW'(int'(a) * 37 + 5);
  endfunction

  logic [DW-1:0] mem [2][16384];
  bit            wrtn [2][16384];
  logic [DW-1:0] pipe0;
  logic [DW-1:0] pipe1 [3];

  function automatic logic [DW-1:0] ram_rd(input int d, input logic [AW-1:0] a);
    return wrtn[d][a] ? mem[d][a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (d0_ram_write) begin mem[0][d0_ram_addr] <= d0_ram_wdata; wrtn[0][d0_ram_addr] <= 1'b1; end
    if (d1_ram_write) begin mem[1][d1_ram_addr] <= d1_ram_wdata; wrtn[1][d1_ram_addr] <= 1'b1; end
    pipe0    <= d0_ram_read ? ram_rd(0, d0_ram_addr) : 10'h3C3;
    pipe1[0] <= d1_ram_read ? ram_rd(1, d1_ram_addr) : 10'h3C3;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign d0_ram_rdata = pipe0;
  assign d1_ram_rdata = pipe1[2];

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_rd [2][8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic clear_exp();
    for (int d = 0; d < 2; d++) for (int i = 0; i < 8; i++) exp_rd[d][i] = '0;
  endtask

  task automatic chk_all_data(input int d, input string nm);
    for (int i = 0; i < NRD[d]; i++) chk(nm, 32'(o_rd[d][i]), 32'(exp_rd[d][i]));
  endtask

  // One isolated transaction: latency, strobe, stall and data of every port.
  task automatic txn(input int d, input bit w, input int p, input logic [AW-1:0] a,
                     input logic [DW-1:0] dat, input logic [DW-1:0] exp_d, input int lat);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (w) begin wq[d] = 1'b1; wa[d] = a; wd[d] = dat; end
    else begin rq[d][p[2:0]] = 1'b1; ra[d][p[2:0]] = a; end
    #1 chk("stall_c0", 32'(o_stall[d]), 1);
    for (int c = 1; c <= 12 && !got; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        chk("strobe_rd", 32'(o_rs[d]), 32'(!w));
        chk("strobe_wr", 32'(o_ws[d]), 32'(w));
        chk("strobe_addr", 32'(o_addr[d]), 32'(a));
        if (w) chk("strobe_wdata", 32'(o_wdata[d]), 32'(dat));
      end else begin
        chk("strobe_idle", 32'(o_rs[d] | o_ws[d]), 0);
      end
      if (o_wrdy[d] || o_rdy[d] != 8'd0) begin
        got = 1'b1;
        chk("ready_latency", 32'(c), 32'(lat));
        chk("ready_vec", 32'({o_wrdy[d], o_rdy[d]}), w ? 32'h100 : (32'h1 << p));
        chk("stall_at_ready", 32'(o_stall[d]), 0);
        if (!w) exp_rd[d][p[2:0]] = exp_d;
        chk_all_data(d, "rd_data");
      end else begin
        chk("stall_wait", 32'(o_stall[d]), 1);
      end
    end
    if (!got) chk("ready_timeout", 0, 1);
    wq[d] = 1'b0;
    rq[d] = '0;
  endtask

  // Hold ports 0..3 requesting and record the first five grants.
  task automatic arb_run(input int d, input int e0, input int e1, input int e2,
                         input int e3, input int e4, input string nm);
    int eo [5];
    int n = 0;
    int p;
    eo = '{e0, e1, e2, e3, e4};
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin rq[d][i] = 1'b1; ra[d][i] = AW'(32'h200 + i); end
    for (int c = 0; c < 80 && n < 5; c++) begin
      @(posedge clk); #1;
      if (o_rdy[d] != 8'd0) begin
        p = 0;
        for (int i = 0; i < 8; i++) if (o_rdy[d][i]) p = i;
        chk({nm, "_onehot"}, 32'($countones(o_rdy[d])), 1);
        chk({nm, "_grant"}, 32'(p), 32'(eo[n]));
        chk({nm, "_data"}, 32'(o_rd[d][p]), 32'(init_val(AW'(32'h200 + p))));
        n++;
      end
    end
    chk({nm, "_count"}, 32'(n), 5);
    rq[d] = '0;
  endtask

  // Reference model state for the random phase.
  int            m_due [2], m_idle [2], m_port [2], m_ptr [2];
  bit            m_wr [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] sh [2][32];

  task automatic model_step(input int d, input int k);
    logic [31:0] exp_rv;
    int w;
    int idx;
    exp_rv = (m_due[d] == k) ? (m_wr[d] ? 32'h100 : (32'h1 << m_port[d])) : 32'h0;
    chk("rnd_ready", 32'({o_wrdy[d], o_rdy[d]}), exp_rv);
    if (m_due[d] == k) begin
      if (!m_wr[d]) exp_rd[d][m_port[d]] = sh[d][m_addr[d][4:0]];
      m_due[d]  = -1;
      m_idle[d] = k + 1;
    end
    chk_all_data(d, "rnd_rd_data");
    chk("rnd_strobe_excl", 32'(o_rs[d] & o_ws[d]), 0);
    if (m_due[d] < 0 && k - 1 >= m_idle[d] && (wq[d] || rq[d] != 8'd0)) begin
      if (wq[d]) begin
        chk("rnd_wr_strobe", 32'({o_ws[d], o_rs[d]}), 32'b10);
        chk("rnd_wr_addr", 32'(o_addr[d]), 32'(wa[d]));
        chk("rnd_wr_data", 32'(o_wdata[d]), 32'(wd[d]));
        sh[d][wa[d][4:0]] = wd[d];
        m_wr[d] = 1'b1; m_addr[d] = wa[d]; m_due[d] = k + 1;
      end else begin
        w = -1;
        for (int j = 0; j < NRD[d]; j++) begin
          idx = RR[d] ? (m_ptr[d] + j) % NRD[d] : j;
          if (w < 0 && rq[d][idx[2:0]]) w = idx;
        end
        if (RR[d] != 0) m_ptr[d] = (w + 1) % NRD[d];
        chk("rnd_rd_strobe", 32'({o_ws[d], o_rs[d]}), 32'b01);
        chk("rnd_rd_addr", 32'(o_addr[d]), 32'(ra[d][w[2:0]]));
        m_wr[d] = 1'b0; m_port[d] = w; m_addr[d] = ra[d][w[2:0]];
        m_due[d] = k + 1 + LAT[d];
      end
    end else begin
      chk("rnd_no_strobe", 32'(o_rs[d] | o_ws[d]), 0);
    end
  endtask

  task automatic drive_step(input int d);
    if (o_wrdy[d]) wq[d] = 1'b0;
    else if (!wq[d] && $urandom_range(0, 5) == 0) begin
      wq[d] = 1'b1;
      wa[d] = AW'(32'h100 + $urandom_range(0, 31));
      wd[d] = DW'($urandom);
    end
    for (int i = 0; i < NRD[d]; i++) begin
      if (o_rdy[d][i]) rq[d][i] = 1'b0;
      else if (!rq[d][i] && $urandom_range(0, 3) == 0) begin
        rq[d][i] = 1'b1;
        ra[d][i] = AW'(32'h100 + $urandom_range(0, 31));
      end
    end
  endtask

  typedef struct {
    int d; bit w; int p; logic [AW-1:0] a; logic [DW-1:0] dat; logic [DW-1:0] exp_d; int lat;
  } vec_t;
  vec_t tbl [13];

  int cw, cr;

  initial begin
    tbl[0]  = '{0, 1'b1, 0, 14'h0012, 10'h155, 10'h000, 2};
    tbl[1]  = '{0, 1'b0, 2, 14'h0012, 10'h000, 10'h155, 3};
    tbl[2]  = '{0, 1'b1, 0, 14'h3FFF, 10'h3FF, 10'h000, 2};
    tbl[3]  = '{0, 1'b0, 3, 14'h3FFF, 10'h000, 10'h3FF, 3};
    tbl[4]  = '{0, 1'b1, 0, 14'h0000, 10'h000, 10'h000, 2};
    tbl[5]  = '{0, 1'b0, 0, 14'h0000, 10'h000, 10'h000, 3};
    tbl[6]  = '{0, 1'b0, 1, 14'h0012, 10'h000, 10'h155, 3};
    tbl[7]  = '{0, 1'b1, 0, 14'h0012, 10'h0AB, 10'h000, 2};
    tbl[8]  = '{0, 1'b0, 2, 14'h0012, 10'h000, 10'h0AB, 3};
    tbl[9]  = '{1, 1'b1, 0, 14'h0555, 10'h1C7, 10'h000, 2};
    tbl[10] = '{1, 1'b0, 7, 14'h0555, 10'h000, 10'h1C7, 5};
    tbl[11] = '{1, 1'b0, 0, 14'h0555, 10'h000, 10'h1C7, 5};
    tbl[12] = '{1, 1'b0, 7, 14'h3FFF, 10'h000, init_val(14'h3FFF), 5};

    for (int d = 0; d < 2; d++) begin
      rq[d] = '0; wq[d] = 1'b0; wa[d] = '0; wd[d] = '0;
      for (int i = 0; i < 8; i++) ra[d][i] = '0;
    end
    clear_exp();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", 32'(o_busy[d]), 0);
      chk("rst_ram_read", 32'(o_rs[d]), 0);
      chk("rst_ram_write", 32'(o_ws[d]), 0);
      chk("rst_ram_addr", 32'(o_addr[d]), 0);
      chk("rst_ready", 32'({o_wrdy[d], o_rdy[d]}), 0);
      chk_all_data(d, "rst_rd_data");
    end
    rst = 1'b1;

    for (int t = 0; t < 13; t++)
      txn(tbl[t].d, tbl[t].w, tbl[t].p, tbl[t].a, tbl[t].dat, tbl[t].exp_d, tbl[t].lat);

    // Write and read to the same address in the same cycle: write goes first.
    @(posedge clk); #1;
    wq[0] = 1'b1; wa[0] = 14'h0040; wd[0] = 10'h2AA;
    rq[0][0] = 1'b1; ra[0][0] = 14'h0040;
    cw = -1; cr = -1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("wprio_strobe", 32'({o_ws[0], o_rs[0]}), 32'b10);
      if (o_wrdy[0]) begin cw = c; wq[0] = 1'b0; end
      if (o_rdy[0][0]) begin cr = c; rq[0][0] = 1'b0; end
    end
    chk("wprio_wr_ready_cycle", 32'(cw), 2);
    chk("wprio_rd_ready_cycle", 32'(cr), 6);
    exp_rd[0][0] = 10'h2AA;
    chk_all_data(0, "wprio_rd_data");

    // Reset during a read's ISSUE cycle aborts it.
    @(posedge clk); #1;
    rq[0][1] = 1'b1; ra[0][1] = 14'h0012;
    @(posedge clk); #1;
    chk("abort_pre_ram_read", 32'(o_rs[0]), 1);
    chk("abort_pre_busy", 32'(o_busy[0]), 1);
    rst = 1'b0;
    #1;
    clear_exp();
    chk("abort_ram_read", 32'(o_rs[0]), 0);
    chk("abort_busy", 32'(o_busy[0]), 0);
    chk("abort_rd_ready", 32'(o_rdy[0]), 0);
    chk_all_data(0, "abort_rd_data");
    rq[0][1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("abort_no_ready", 32'({o_wrdy[0], o_rdy[0]}), 0);
    end

    arb_run(1, 0, 1, 2, 3, 0, "rr");
    arb_run(0, 0, 0, 0, 0, 0, "fixed");

    // Random traffic against the reference model.
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rq[d] = '0; wq[d] = 1'b0;
      m_due[d] = -1; m_idle[d] = -1; m_port[d] = 0; m_ptr[d] = 0; m_wr[d] = 1'b0; m_addr[d] = '0;
      for (int i = 0; i < 32; i++) sh[d][i] = ram_rd(d, AW'(32'h100 + i));
    end
    clear_exp();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) model_step(d, k);
      for (int d = 0; d < 2; d++) drive_step(d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
